imem_loader: RTL and testbench

Byte-stream program loader and the write side of the instruction ROM/EBRAM. It accepts a length-prefixed little-endian byte stream over a valid/ready interface and assembles 32-bit words. Each word is written with a single-cycle write strobe into the instruction memory's write port. The CPU is held in reset until the image is fully written, and a status flag reports success or a rejected image.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input handshake plus the instruction-memory
// write port of the program loader.
//   master : the stream source / memory side (drives in_valid, in_data)
//   slave  : the loader itself (drives in_ready and the write port)
interface imem_loader_if #(
  parameter int DEPTH_LOG = 12,
  parameter int WIDTH     = 32
);
  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 in_ready;
  logic                 we;
  logic [DEPTH_LOG-1:0] waddr;
  logic [WIDTH-1:0]     wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: length-prefixed little-endian byte-stream program loader.
// Receives a 16-bit word count N followed by 4N payload bytes. It packs each
// group of 4 bytes into a 32-bit word and writes it with a one-cycle strobe
// into the instruction memory. The CPU is held in reset (cpu_reset_n=0)
// until the whole image has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all payload bytes. A mismatch rejects the image.
module imem_loader #(
  parameter int DEPTH     = 3072,
  parameter int DEPTH_LOG = 12,
  parameter int WIDTH     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_loader_if.slave bus,
  output logic         cpu_reset_n,
  output logic         done,
  output logic         error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    HDR_LO, HDR_HI, DATA, DONE, ERR
  } state_t;
`endif

  localparam logic [15:0]        DEPTH_HDR = 16'(DEPTH);
  localparam logic [DEPTH_LOG:0] IDX_ONE   = (DEPTH_LOG+1)'(1);

  state_t               state;
  logic [7:0]           n_lo;       // low byte of the header
  logic [DEPTH_LOG:0]   n_words;    // accepted image length in words
  logic [DEPTH_LOG:0]   word_idx;   // index of the word being assembled
  logic [1:0]           lane;       // byte position inside the current word
  logic [WIDTH-9:0]     partial;    // bytes 0..2 of the current word
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           csum;       // running XOR of the payload bytes
`endif

  logic        accept;
  logic [15:0] n_hdr;
  logic        last_word;

  // A byte transfers only when both sides agree on this edge.
  assign accept    = bus.in_valid && bus.in_ready;
  // Full header value while the high byte is on the bus.
  assign n_hdr     = {bus.in_data, n_lo};
  // The word being completed is the final one of the image.
  assign last_word = (word_idx + IDX_ONE) == n_words;

  // Loader FSM: header decode, word assembly, write strobe, completion flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HDR_LO;
      n_lo        <= '0;
      n_words     <= '0;
      word_idx    <= '0;
      lane        <= '0;
      partial     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      cpu_reset_n  <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values and the default below is cleanly overridden.
      bus.we <= 1'b0;

      case (state)
        HDR_LO: begin
          // in_ready rises on the first edge out of reset.
          bus.in_ready <= 1'b1;
          if (accept) begin
            n_lo  <= bus.in_data;
            state <= HDR_HI;
          end
        end

        HDR_HI: begin
          if (accept) begin
            word_idx <= '0;
            lane     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            if (n_hdr == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state        <= DONE;
              bus.in_ready <= 1'b0;
`endif
            end else if (n_hdr > DEPTH_HDR) begin
              state        <= ERR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else begin
              n_words <= n_hdr[DEPTH_LOG:0];
              state   <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            if (lane == 2'd3) begin
              // Fourth byte completes the word: strobe it out this edge.
              bus.we    <= 1'b1;
              bus.waddr <= word_idx[DEPTH_LOG-1:0];
              bus.wdata <= {bus.in_data, partial};
              word_idx  <= word_idx + IDX_ONE;
              lane      <= 2'd0;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state        <= DONE;
                bus.in_ready <= 1'b0;
`endif
              end
            end else begin
              partial[8*lane +: 8] <= bus.in_data;
              lane                 <= lane + 2'd1;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state <= DONE;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          // Released one cycle after the final write so it commits first.
          bus.in_ready <= 1'b0;
          done         <= 1'b1;
          cpu_reset_n  <= 1'b1;
        end

        ERR: begin
          bus.in_ready <= 1'b0;
          error        <= 1'b1;
          cpu_reset_n  <= 1'b0;
        end

        default: begin
          state        <= ERR;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized images checked against a
// behavioural model of the loader (word list, final status, byte count).
module tb_imem_loader;
  localparam int DEPTH     = 3072;
  localparam int DEPTH_LOG = 12;
  localparam int WIDTH     = 32;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_reset_n, done, error;

  imem_loader_if #(.DEPTH_LOG(DEPTH_LOG), .WIDTH(WIDTH)) bus ();

  imem_loader #(.DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  wr_t wr_q[$];
  int  acc_cyc_q[$];

  // Record every write strobe with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.we === 1'b1) wr_q.push_back('{int'(bus.waddr), bus.wdata, cyc});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wr_t wr_at(input int k);
    wr_t w;
    w = '{-1, 'x, -1};
    if (k < wr_q.size()) w = wr_q[k];
    return w;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] exp_words[$];
  bit          exp_done, exp_error;
  int          exp_consumed;

  function automatic void ref_model(input bq_t img);
    int         n;
    logic [7:0] x;
    exp_words.delete();
    exp_done  = 0;
    exp_error = 0;
    n = int'({img[1], img[0]});
    exp_consumed = 2;
    if (n > DEPTH) begin
      exp_error = 1;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_words.push_back({img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
      for (int b = 0; b < 4; b++) x = x ^ img[2+4*w+b];
    end
    exp_consumed = 2 + 4*n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_consumed++;
    if (img[exp_consumed-1] == x) exp_done = 1;
    else                          exp_error = 1;
`else
    exp_done = 1;
`endif
  endfunction

  function automatic bq_t make_image(input int n, input bit bad_csum);
    bq_t        q;
    logic [7:0] x, b;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    x = 8'h00;
    if (n <= DEPTH) begin
      for (int i = 0; i < 4*n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        q.push_back(b);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      q.push_back(bad_csum ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
`else
      if (bad_csum) q.push_back(8'h00);   // trailing byte, ignored
`endif
    end
    return q;
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic do_reset(input bit verify);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset_n      = 1'b0;
    @(negedge clk);
    if (verify) begin
      check("rst_in_ready",    32'(bus.in_ready),  32'd0);
      check("rst_we",          32'(bus.we),        32'd0);
      check("rst_waddr",       32'(bus.waddr),     32'd0);
      check("rst_wdata",       bus.wdata,          32'd0);
      check("rst_cpu_reset_n", 32'(cpu_reset_n),   32'd0);
      check("rst_done",        32'(done),          32'd0);
      check("rst_error",       32'(error),         32'd0);
    end
    reset_n = 1'b1;
    wr_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    check("ready_after_reset", 32'(bus.in_ready), 32'd1);
  endtask

  // Starts and ends at a falling edge; returns once the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 0;
    for (int t = 0; t < 64; t++) begin
      if (bus.in_ready === 1'b1) begin
        @(negedge clk);
        acc_cyc_q.push_back(cyc);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_image(input bq_t img, input int gap, input int extra);
    bit ok;
    wr_t w;
    ref_model(img);
    for (int i = 0; i < exp_consumed; i++) begin
      send_byte(img[i], (i == 0) ? 0 : gap, ok);
      check("byte_accepted", 32'(ok), 32'd1);
      if (!ok) return;
    end
    if (exp_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("ready_low_at_last", 32'(bus.in_ready), 32'd0);
`else
      if (exp_words.size() > 0) check("ready_low_at_last", 32'(bus.in_ready), 32'd0);
`endif
      check("done_not_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("done",        32'(done),        32'(exp_done));
    check("error",       32'(error),       32'(exp_error));
    check("cpu_reset_n", 32'(cpu_reset_n), 32'(exp_done));
    check("ready_end",   32'(bus.in_ready), 32'd0);
    // Bytes offered after completion must be ignored.
    bus.in_valid = 1'b1;
    repeat (extra) begin
      bus.in_data = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("we_count", 32'(wr_q.size()), 32'(exp_words.size()));
    for (int k = 0; k < exp_words.size(); k++) begin
      w = wr_at(k);
      check("waddr",   32'(w.addr), 32'(k));
      check("wdata",   w.data,      exp_words[k]);
      check("we_lat",  32'(w.cyc),  32'(acc_cyc_q[4*k+5]));
    end
    check("done_sticky",  32'(done),  32'(exp_done));
    check("error_sticky", 32'(error), 32'(exp_error));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bq_t img;
    bit  ok;
    wr_t w0, w1;
    int  n;
    bit  bad;

    // Basic image, streaming back-to-back.
    do_reset(1);
    img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(8'h2A);
`endif
    run_image(img, 0, 3);
    w0 = wr_at(0);
    w1 = wr_at(1);
    check("basic_w0", w0.data, 32'h12345678);
    check("basic_w1", w1.data, 32'hDEADBEEF);
    check("basic_spacing", 32'(w1.cyc - w0.cyc), 32'd4);

    // Throttled: 3 idle cycles between every byte.
    do_reset(0);
    run_image(img, 3, 0);
    w0 = wr_at(0);
    w1 = wr_at(1);
    check("thr_w0", w0.data, 32'h12345678);
    check("thr_w1", w1.data, 32'hDEADBEEF);

    // Empty image.
    do_reset(0);
    img = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(8'h00);
`endif
    run_image(img, 0, 2);

    // Oversize header N=3073, trailing bytes ignored.
    do_reset(0);
    img = '{8'h01, 8'h0C, 8'h11, 8'h22, 8'h33, 8'h44};
    run_image(img, 0, 6);

    // Largest legal image, N=DEPTH.
    do_reset(0);
    run_image(make_image(DEPTH, 0), 0, 0);

    // Mid-load reset after 5 accepted bytes.
    do_reset(0);
    img = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    foreach (img[i]) send_byte(img[i], 0, ok);
    #2 reset_n = 1'b0;
    #1;
    check("mid_in_ready",    32'(bus.in_ready), 32'd0);
    check("mid_we",          32'(bus.we),       32'd0);
    check("mid_waddr",       32'(bus.waddr),    32'd0);
    check("mid_wdata",       bus.wdata,         32'd0);
    check("mid_cpu_reset_n", 32'(cpu_reset_n),  32'd0);
    check("mid_done",        32'(done),         32'd0);
    check("mid_error",       32'(error),        32'd0);
    do_reset(0);
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(8'h44);
`endif
    run_image(img, 0, 0);
    w0 = wr_at(0);
    check("reload_addr", 32'(w0.addr), 32'd0);
    check("reload_data", w0.data, 32'h44332211);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accepted and rejected.
    do_reset(0);
    img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_image(img, 0, 0);
    check("csum_ok_done", 32'(done), 32'd1);
    do_reset(0);
    img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    run_image(img, 0, 2);
    w0 = wr_at(0);
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_cpu",   32'(cpu_reset_n), 32'd0);
    check("csum_bad_word",  w0.data, 32'h12345678);
`endif

    // Randomized images against the model.
    for (int it = 0; it < 12; it++) begin
      bad = ($urandom_range(0, 2) == 0);
      n   = (it % 5 == 4) ? $urandom_range(DEPTH+1, 65535) : $urandom_range(1, 6);
      do_reset(0);
      run_image(make_image(n, bad), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
